// File: rtl/csa_accumulator.sv
// Purpose : sums groups of unsigned operands in carry-save form, resolving the carry chain chunk-by-chunk at group end.
// Latency : one operand per cycle while accumulating; out_valid rises NCH+1 cycles after the in_last accept.
// Backpr. : in_ready low while resolving/presenting; result held stable until out_ready is seen with out_valid.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   in_valid/in_ready/in_data   operand handshake; in_data zero-extended to ACC_W
//   in_last                     final operand of the group (sampled on accept)
//   out_valid/out_ready         result handshake
//   out_sum                     group sum modulo 2^ACC_W
//   out_count                   operands in the group, saturating at all-ones
//   out_ovf                     out_count exceeds 2^(ACC_W-WIDTH)
module csa_accumulator #(
   parameter int WIDTH = 16,
   parameter int ACC_W = 24,
   parameter int CHUNK = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_sum,
   output logic [ACC_W-WIDTH:0]   out_count,
   output logic                   out_ovf
);

   localparam int NCH   = ACC_W / CHUNK;
   localparam int CNT_W = ACC_W - WIDTH + 1;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   // 2^(ACC_W-WIDTH): beyond this many operands the sum may have wrapped
   localparam logic [CNT_W-1:0] OVF_LIM  = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

   typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] s_q, s_d;
   logic [ACC_W-1:0] c_q, c_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             rcy_q, rcy_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [ACC_W-1:0] x_ext;
   logic [CHUNK:0]   chunk_add;
   logic             accept;
   logic             take;

   assign x_ext  = {{(ACC_W-WIDTH){1'b0}}, in_data};
   // in_ready_q / out_valid_q are exact state decodes, so they double as state qualifiers
   assign accept = in_valid & in_ready_q;
   assign take   = out_valid_q & out_ready;

   // S and C are shifted right each resolve cycle, so the current chunk is always the low CHUNK bits
   assign chunk_add = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, rcy_q};

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      c_d     = c_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      rcy_d   = rcy_q;
      idx_d   = idx_q;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               s_d = s_q ^ c_q ^ x_ext;
               c_d = ((s_q & c_q) | (s_q & x_ext) | (c_q & x_ext)) << 1;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
               ovf_d = (cnt_d > OVF_LIM);
               if (in_last) begin
                  state_d = RESOLVE;
                  rcy_d   = 1'b0;
                  idx_d   = '0;
               end
            end
         end
         RESOLVE: begin
            s_d   = s_q >> CHUNK;
            c_d   = c_q >> CHUNK;
            // result chunks enter from the top; after NCH cycles chunk 0 sits at the bottom
            sum_d = (sum_q >> CHUNK) | (ACC_W'(chunk_add[CHUNK-1:0]) << (ACC_W - CHUNK));
            // carry out of the top chunk is simply never consumed
            rcy_d = chunk_add[CHUNK];
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            if (take) begin
               state_d = ACCUM;
               s_d     = '0;
               c_d     = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ACCUM;
      endcase
      in_ready_d  = (state_d == ACCUM);
      out_valid_d = (state_d == OUTPUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         s_q         <= '0;
         c_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         rcy_q       <= 1'b0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         c_q         <= c_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         rcy_q       <= rcy_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator (WIDTH=16, ACC_W=24, CHUNK=8): a transaction-level model
// (plain integer sums) is checked every cycle, plus literal expectations for fixed groups.
module tb_csa_accumulator;

   localparam int NCH = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_sum;
   logic [8:0]  out_count;
   logic        out_ovf;

   int n_vec = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   csa_accumulator #(.WIDTH(16), .ACC_W(24), .CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode 0: taking operands, 1: resolving (m_wait cycles left), 2: presenting result
   int          m_mode = 0;
   int          m_wait = 0;
   longint      m_sum  = 0;
   int          m_cnt  = 0;
   longint      e_sum  = 0;
   int          e_cnt  = 0;
   logic        e_ovf  = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", in_ready, m_mode == 0);
         check("out_valid", out_valid, m_mode == 2);
         if (m_mode == 2) begin
            check("out_sum", out_sum, e_sum);
            check("out_count", out_count, e_cnt);
            check("out_ovf", out_ovf, e_ovf);
         end
         // inputs are stable until after the next rising edge: predict what it does
         if (rst) begin
            m_mode = 0; m_sum = 0; m_cnt = 0;
         end else begin
            case (m_mode)
               0: if (in_valid) begin
                  m_sum += longint'(in_data);
                  m_cnt++;
                  if (in_last) begin
                     m_mode = 1;
                     m_wait = NCH;
                     e_sum  = m_sum % (longint'(1) << 24);
                     e_cnt  = (m_cnt > 511) ? 511 : m_cnt;
                     e_ovf  = (m_cnt > 256);
                  end
               end
               1: begin
                  m_wait--;
                  if (m_wait == 0) m_mode = 2;
               end
               default: if (out_ready) begin
                  m_mode = 0; m_sum = 0; m_cnt = 0;
               end
            endcase
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [15:0] d, input logic last);
      in_valid = 1'b1; in_data = d; in_last = last;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_rand_group(input int n, output longint s);
      int sent;
      sent = 0; s = 0;
      while (sent < n) begin
         in_data  = 16'($urandom);
         in_valid = 1'($urandom_range(0, 1));
         in_last  = (sent == n - 1);
         @(posedge clk); #1;
         if (in_valid) begin
            s += longint'(in_data);
            sent++;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // called just after the in_last accept edge; lat counts cycles from the accept cycle
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("out_valid_timeout", out_valid, 1'b1);
   endtask

   task automatic take;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int     lat;
      longint rs;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      rst = 1'b0;
      @(posedge clk); #1;
      // reset state
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sum", out_sum, 24'h0);
      check("rst_out_count", out_count, 9'd0);
      check("rst_out_ovf", out_ovf, 1'b0);

      // 0xFFFF + 0xFFFF + 0x0001, with latency and 5-cycle stall
      send(16'hFFFF, 1'b0);
      send(16'hFFFF, 1'b0);
      send(16'h0001, 1'b1);
      wait_out(lat);
      check("g1_latency", lat, 4);
      check("g1_sum", out_sum, 24'h01FFFF);
      check("g1_count", out_count, 9'd3);
      check("g1_ovf", out_ovf, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_sum", out_sum, 24'h01FFFF);
         check("stall_count", out_count, 9'd3);
         check("stall_in_ready", in_ready, 1'b0);
      end
      take();
      check("after_take_in_ready", in_ready, 1'b1);
      check("after_take_out_valid", out_valid, 1'b0);
      // next group starts from zero
      send(16'h0003, 1'b1);
      wait_out(lat);
      check("fresh_sum", out_sum, 24'h000003);
      check("fresh_count", out_count, 9'd1);
      take();

      // single operand
      send(16'h1234, 1'b1);
      wait_out(lat);
      check("single_sum", out_sum, 24'h001234);
      check("single_count", out_count, 9'd1);
      check("single_ovf", out_ovf, 1'b0);
      take();

      // 257 x 0xFFFF: count overflow flag, sum wraps
      for (int i = 0; i < 257; i++) send(16'hFFFF, i == 256);
      wait_out(lat);
      check("big_sum", out_sum, 24'h00FEFF);
      check("big_count", out_count, 9'd257);
      check("big_ovf", out_ovf, 1'b1);
      take();

      // reset in the second resolve cycle
      send(16'h00AA, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_sum", out_sum, 24'h0);
      check("midrst_count", out_count, 9'd0);
      repeat (6) @(posedge clk);
      #1;
      check("midrst_still_idle", out_valid, 1'b0);
      send(16'h0005, 1'b1);
      wait_out(lat);
      check("postrst_sum", out_sum, 24'h000005);
      check("postrst_count", out_count, 9'd1);
      take();

      // 10 operands with in_valid toggling
      send_rand_group(10, rs);
      wait_out(lat);
      check("rand10_sum", out_sum, rs % (longint'(1) << 24));
      check("rand10_count", out_count, 9'd10);
      take();

      // random groups with random consumer stalls; checked by the per-cycle model
      for (int g = 0; g < 8; g++) begin
         send_rand_group($urandom_range(1, 40), rs);
         wait_out(lat);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         take();
      end
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete (vectors %0d, miscompares %0d)", n_vec, n_err);
      $fatal(1, "watchdog");
   end

endmodule
